// File: rtl/pool1_row_packer_if.sv
// pool1_row_packer_if: pixel input stream and packed pooled-row output bus.
// master drives pixels and samples rows; slave is the packer itself.
interface pool1_row_packer_if #(
   parameter int DW    = 16,
   parameter int OUT_W = 14
);
   logic                  in_valid;
   logic [DW-1:0]         in_data;
   logic [OUT_W*DW-1:0]   out_row;
   logic                  out_valid;
   logic [3:0]            out_row_idx;
   logic                  frame_done;
   modport master (
      output in_valid, in_data,
      input  out_row, out_valid, out_row_idx, frame_done
   );
   modport slave (
      input  in_valid, in_data,
      output out_row, out_valid, out_row_idx, frame_done
   );
endinterface

// File: rtl/pool1_row_packer.sv
// pool1_row_packer: streaming 2x2 signed max-pool emitting one packed row per odd input row.
// Define POOL1_ROW_RELU_EN to clamp negative pooled outputs to zero.
module pool1_row_packer #(
   parameter int DW   = 16,
   parameter int IN_W = 28,
   parameter int IN_H = 28
) (
   input logic               clk,
   input logic               rst,
   pool1_row_packer_if.slave bus
);
   localparam int OUT_W = IN_W / 2;
   localparam int CW    = $clog2(IN_W);
   localparam int RW    = $clog2(IN_H);

   typedef enum logic {EVEN_ROW, ODD_ROW} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic signed [DW-1:0] hold_q, hold_d;
   logic signed [DW-1:0] line_q [OUT_W];
   logic signed [DW-1:0] line_d [OUT_W];
   logic signed [DW-1:0] stage_q [OUT_W];
   logic signed [DW-1:0] stage_d [OUT_W];
   logic [OUT_W*DW-1:0]  out_row_q, out_row_d;
   logic                 out_valid_q, out_valid_d;
   logic [3:0]           idx_q, idx_d;
   logic                 frame_done_q, frame_done_d;
   logic signed [DW-1:0] pix, hmax, vmax;
   logic [CW-2:0]        half;
   logic                 col_wrap;

   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
      return a > b ? a : b;
   endfunction

   function automatic logic [DW-1:0] clamp(input logic signed [DW-1:0] v);
`ifdef POOL1_ROW_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign half = col_q[CW-1:1];

   always_comb begin
      pix          = $signed(bus.in_data);
      hmax         = smax(hold_q, pix);
      vmax         = smax(line_q[half], hmax);
      col_wrap     = col_q == CW'(IN_W - 1);
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      line_d       = line_q;
      stage_d      = stage_q;
      out_row_d    = out_row_q;
      idx_d        = idx_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      if (bus.in_valid) begin
         col_d = col_wrap ? '0 : col_q + 1'b1;
         if (col_wrap) begin
            row_d   = row_q == RW'(IN_H - 1) ? '0 : row_q + 1'b1;
            state_d = state_q == EVEN_ROW ? ODD_ROW : EVEN_ROW;
         end
         if (!col_q[0])
            hold_d = pix;
         else if (state_q == EVEN_ROW)
            line_d[half] = hmax;
         else
            stage_d[half] = vmax;
         // last column of an odd row: final element comes straight from vmax, not stage
         if (state_q == ODD_ROW && col_wrap) begin
            for (int k = 0; k < OUT_W; k++)
               out_row_d[k*DW +: DW] = clamp(k == OUT_W - 1 ? vmax : stage_q[k]);
            out_valid_d  = 1'b1;
            idx_d        = 4'(row_q >> 1);
            frame_done_d = row_q == RW'(IN_H - 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EVEN_ROW;
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         line_q       <= '{default: '0};
         stage_q      <= '{default: '0};
         out_row_q    <= '0;
         out_valid_q  <= 1'b0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         line_q       <= line_d;
         stage_q      <= stage_d;
         out_row_q    <= out_row_d;
         out_valid_q  <= out_valid_d;
         idx_q        <= idx_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.out_row     = out_row_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_row_idx = idx_q;
   assign bus.frame_done  = frame_done_q;
endmodule
